// File: rtl/matrix_vector_fetch_sequencer.sv
// rtl/matrix_vector_fetch_sequencer.sv - vector + matrix-row read sequencer feeding the MAC array
//
// Purpose: on a command, reads one vector entry on memory port A, then fetches
// row_count matrix rows (16 x 2b elements each) on port B, packs each row into
// one word and streams it out with valid/ready. Never writes memory.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only while idle)
//   cmd_unit_id, cmd_vec_idx        vector location {unit_id, vec_idx}
//   cmd_row_base, cmd_row_count     first matrix row (wraps mod 16), rows to fetch 0..16
//   mem_addr_a/mem_we_a/mem_data_a  memory port A (vector), 1-cycle registered read
//   mem_addr_b/mem_we_b/mem_data_b  memory port B (matrix element), 1-cycle registered read
//   mem_err                         [1] port A error, [0] port B error, aligned with read data
//   vec_data                        captured vector, stable until the next accepted command
//   row_valid/row_ready             row stream handshake
//   row_data, row_idx, row_last     packed row (element c at [2c+1:2c]), its row index, final-row flag
//   done, err                       one-cycle end-of-command pulse, err=1 when aborted on a memory error

module matrix_vector_fetch_sequencer #(
    parameter int VECTOR_WIDTH = 32,
    parameter int MAT_DIM      = 16,
    parameter int ELEM_W       = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_unit_id,
    input  logic [3:0]                cmd_vec_idx,
    input  logic [3:0]                cmd_row_base,
    input  logic [4:0]                cmd_row_count,
    output logic [5:0]                mem_addr_a,
    output logic                      mem_we_a,
    input  logic [VECTOR_WIDTH-1:0]   mem_data_a,
    output logic [7:0]                mem_addr_b,
    output logic                      mem_we_b,
    input  logic [ELEM_W-1:0]         mem_data_b,
    input  logic [1:0]                mem_err,
    output logic [VECTOR_WIDTH-1:0]   vec_data,
    output logic                      row_valid,
    input  logic                      row_ready,
    output logic [MAT_DIM*ELEM_W-1:0] row_data,
    output logic [3:0]                row_idx,
    output logic                      row_last,
    output logic                      done,
    output logic                      err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEC_RD,
        S_VEC_CAP,
        S_ROW_RD,
        S_ROW_CAP,
        S_ROW_OUT,
        S_FIN
    } state_t;

    state_t                    state;
    state_t                    next_state;

    logic [1:0]                unit_q;
    logic [3:0]                vec_idx_q;
    logic [3:0]                row_q;
    logic [4:0]                rows_left_q;
    logic [3:0]                col_q;
    logic [3:0]                slot;
    logic [VECTOR_WIDTH-1:0]   vec_q;
    logic [MAT_DIM*ELEM_W-1:0] row_buf;
    logic [7:0]                addr_b_q;
    logic                      err_q;
    logic                      cap_en;
    logic                      set_err;
    logic                      row_hs;

    // Element data lags its address by one cycle: while issuing col c (c>0)
    // we capture col c-1; ROW_CAP captures col 15 (col_q has wrapped to 0,
    // so col_q-1 lands on slot 15 without a special case).
    assign cap_en  = ((state == S_ROW_RD) && (col_q != 4'd0)) || (state == S_ROW_CAP);
    assign slot    = col_q - 4'd1;
    assign set_err = ((state == S_VEC_CAP) && mem_err[1]) || (cap_en && mem_err[0]);
    assign row_hs  = (state == S_ROW_OUT) && row_ready;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (cmd_valid) next_state = S_VEC_RD;
            S_VEC_RD:  next_state = S_VEC_CAP;
            S_VEC_CAP: begin
                if (mem_err[1] || (rows_left_q == 5'd0)) next_state = S_FIN;
                else                                     next_state = S_ROW_RD;
            end
            S_ROW_RD: begin
                if (cap_en && mem_err[0])  next_state = S_FIN;
                else if (col_q == 4'd15)   next_state = S_ROW_CAP;
            end
            S_ROW_CAP: begin
                if (mem_err[0]) next_state = S_FIN;
                else            next_state = S_ROW_OUT;
            end
            S_ROW_OUT: begin
                if (row_ready) begin
                    if (rows_left_q == 5'd1) next_state = S_FIN;
                    else                     next_state = S_ROW_RD;
                end
            end
            S_FIN:     next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            unit_q      <= '0;
            vec_idx_q   <= '0;
            row_q       <= '0;
            rows_left_q <= '0;
            col_q       <= '0;
            vec_q       <= '0;
            row_buf     <= '0;
            addr_b_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state <= next_state;

            if ((state == S_IDLE) && cmd_valid) begin
                unit_q      <= cmd_unit_id;
                vec_idx_q   <= cmd_vec_idx;
                row_q       <= cmd_row_base;
                rows_left_q <= cmd_row_count;
                col_q       <= 4'd0;
                err_q       <= 1'b0;
            end

            if (state == S_VEC_CAP) vec_q <= mem_data_a;

            if (state == S_ROW_RD) begin
                addr_b_q <= {row_q, col_q};
                col_q    <= col_q + 4'd1;
            end

            if (cap_en) row_buf[ELEM_W*slot +: ELEM_W] <= mem_data_b;

            if (row_hs) begin
                row_q       <= row_q + 4'd1;
                rows_left_q <= rows_left_q - 5'd1;
            end

            if (set_err) err_q <= 1'b1;
        end
    end

    assign cmd_ready  = (state == S_IDLE);
    assign mem_addr_a = {unit_q, vec_idx_q};
    assign mem_we_a   = 1'b0;
    // Port B address only moves while issuing; otherwise it holds the last issued one.
    assign mem_addr_b = (state == S_ROW_RD) ? {row_q, col_q} : addr_b_q;
    assign mem_we_b   = 1'b0;
    // Read data is forwarded during the capture cycle so the vector is usable
    // two cycles after acceptance; afterwards the registered copy holds it.
    assign vec_data   = (state == S_VEC_CAP) ? mem_data_a : vec_q;
    assign row_valid  = (state == S_ROW_OUT);
    assign row_data   = row_buf;
    assign row_idx    = row_q;
    assign row_last   = (state == S_ROW_OUT) && (rows_left_q == 5'd1);
    assign done       = (state == S_FIN);
    assign err        = (state == S_FIN) && err_q;

endmodule

// File: tb/tb_matrix_vector_fetch_sequencer.sv
// tb/tb_matrix_vector_fetch_sequencer.sv - self-checking bench for matrix_vector_fetch_sequencer

module tb_matrix_vector_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_unit_id = '0;
    logic [3:0]  cmd_vec_idx = '0;
    logic [3:0]  cmd_row_base = '0;
    logic [4:0]  cmd_row_count = '0;
    logic [5:0]  mem_addr_a;
    logic        mem_we_a;
    logic [31:0] mem_data_a = '0;
    logic [7:0]  mem_addr_b;
    logic        mem_we_b;
    logic [1:0]  mem_data_b = '0;
    logic [1:0]  mem_err = '0;
    logic [31:0] vec_data;
    logic        row_valid;
    logic        row_ready = 1'b0;
    logic [31:0] row_data;
    logic [3:0]  row_idx;
    logic        row_last;
    logic        done;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] vec_mem [64];
    logic [1:0]  mat_mem [256];
    logic        err_a_en = 1'b0;
    logic        err_b_en = 1'b0;
    logic [7:0]  err_b_addr = '0;

    always #5 clk = ~clk;

    matrix_vector_fetch_sequencer #(
        .VECTOR_WIDTH(32), .MAT_DIM(16), .ELEM_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_unit_id(cmd_unit_id), .cmd_vec_idx(cmd_vec_idx),
        .cmd_row_base(cmd_row_base), .cmd_row_count(cmd_row_count),
        .mem_addr_a(mem_addr_a), .mem_we_a(mem_we_a), .mem_data_a(mem_data_a),
        .mem_addr_b(mem_addr_b), .mem_we_b(mem_we_b), .mem_data_b(mem_data_b),
        .mem_err(mem_err),
        .vec_data(vec_data),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .row_idx(row_idx), .row_last(row_last),
        .done(done), .err(err)
    );

    // Memory model: 1-cycle registered read, error flags aligned with read data.
    always @(posedge clk) begin
        mem_data_a <= vec_mem[mem_addr_a];
        mem_data_b <= mat_mem[mem_addr_b];
        mem_err    <= {err_a_en, err_b_en && (mem_addr_b == err_b_addr)};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_flags"}, {cmd_ready, row_valid, row_last, done, err, mem_we_a, mem_we_b}, 7'b1000000);
        check({tag, "_vec_data"}, vec_data, 0);
        check({tag, "_row_data"}, row_data, 0);
        check({tag, "_row_idx"}, row_idx, 0);
        check({tag, "_addr_a"}, mem_addr_a, 0);
        check({tag, "_addr_b"}, mem_addr_b, 0);
    endtask

    function automatic logic [31:0] pack_row(input logic [3:0] r);
        logic [31:0] d;
        d = '0;
        for (int c = 0; c < 16; c++) d[2*c +: 2] = mat_mem[{r, c[3:0]}];
        return d;
    endfunction

    // One command against the reference rules. Cycle 0 is the accept cycle.
    // errk/errc: row ordinal and column whose element read reports a port-B error (-1 = none).
    // rst_at: cycle at which rst_n is pulled low (0 = never). busy_at: cycle of an ignored cmd_valid pulse.
    task automatic run_cmd(input logic [1:0] unit, input logic [3:0] vidx, input logic [3:0] base,
                           input logic [4:0] cnt, input int stall, input bit erra,
                           input int errk, input int errc, input int rst_at, input int busy_at);
        int          exp_rows, n_rows, stall_left, exp_start, rd_start, hs, exp_done;
        bit          in_out, seen_done;
        logic [7:0]  addr_b0;
        logic [3:0]  r;
        logic [31:0] exp_vec;

        exp_rows = erra ? 0 : ((errk >= 0) ? errk : int'(cnt));
        if (errk >= 0) begin
            r          = base + errk[3:0];
            err_b_addr = {r, errc[3:0]};
            err_b_en   = 1'b1;
        end
        err_a_en      = erra;
        addr_b0       = mem_addr_b;
        exp_vec       = vec_mem[{unit, vidx}];
        cmd_unit_id   = unit;
        cmd_vec_idx   = vidx;
        cmd_row_base  = base;
        cmd_row_count = cnt;
        cmd_valid     = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1);

        n_rows = 0; stall_left = stall; exp_start = 20; rd_start = 3; hs = 0;
        in_out = 0; seen_done = 0;

        for (int cyc = 1; cyc <= 700; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                cmd_valid = 1'b0;
                check("mem_addr_a", mem_addr_a, {unit, vidx});
                check("we_tied_low", {mem_we_a, mem_we_b}, 2'b00);
            end
            if (cyc == busy_at) begin
                cmd_valid     = 1'b1;
                cmd_unit_id   = ~unit;
                cmd_vec_idx   = ~vidx;
                cmd_row_base  = base + 4'd7;
                cmd_row_count = 5'd16;
                check("cmd_ready_busy", cmd_ready, 0);
            end
            if (busy_at > 0 && cyc == busy_at + 1) cmd_valid = 1'b0;
            if (cyc == 2) check("vec_data", vec_data, exp_vec);

            if (rst_at > 0 && cyc > rst_at) begin
                if (cyc == rst_at + 1) begin
                    check_reset("rst_mid");
                    rst_n = 1'b1;
                end else begin
                    check("no_done_after_rst", {done, row_valid}, 2'b00);
                end
                if (cyc == rst_at + 5) break;
                continue;
            end
            if (rst_at > 0 && cyc == rst_at) rst_n = 1'b0;

            if (row_valid) begin
                r = base + n_rows[3:0];
                check("row_in_budget", n_rows < exp_rows, 1);
                if (!in_out) begin
                    check("row_start_cycle", cyc, exp_start);
                    in_out = 1;
                end
                check("row_idx", row_idx, r);
                check("row_data", row_data, pack_row(r));
                check("row_last", row_last, (n_rows + 1) == int'(cnt));
                if (stall_left > 0) begin
                    row_ready = 1'b0;
                    stall_left--;
                    check("addr_b_hold", mem_addr_b, {r, 4'hf});
                end else begin
                    row_ready = 1'b1;
                end
                if (row_ready) begin
                    n_rows++;
                    in_out    = 0;
                    exp_start = cyc + 18;
                    rd_start  = cyc + 1;
                    hs        = cyc;
                end
            end else begin
                row_ready = 1'($urandom_range(0, 1));
            end

            if (done) begin
                if (erra || cnt == 0) exp_done = 3;
                else if (errk >= 0)   exp_done = rd_start + errc + 2;
                else                  exp_done = hs + 1;
                check("done_cycle", cyc, exp_done);
                check("err", err, erra || (errk >= 0));
                check("rows_emitted", n_rows, exp_rows);
                if (erra || cnt == 0) check("addr_b_untouched", mem_addr_b, addr_b0);
                seen_done = 1;
                @(posedge clk); #1;
                check("idle_after_done", {cmd_ready, done, row_valid}, 3'b100);
                break;
            end
        end
        if (rst_at == 0) check("done_seen", seen_done, 1);
        err_a_en  = 1'b0;
        err_b_en  = 1'b0;
        row_ready = 1'b0;
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [4:0] rc;
        int         ek, ec;

        for (int i = 0; i < 64; i++)  vec_mem[i] = $urandom;
        for (int i = 0; i < 256; i++) mat_mem[i] = 2'($urandom);
        for (int c = 0; c < 16; c++)  mat_mem[{4'd3, c[3:0]}] = 2'(c % 4);
        vec_mem[{2'd2, 4'd5}] = 32'hDEADBEEF;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single row, known pattern
        check("t1_row3_model", pack_row(4'd3), 32'hE4E4E4E4);
        run_cmd(2'd2, 4'd5, 4'd3, 5'd1, 0, 0, -1, 0, 0, 0);
        // Row index wrap 14,15,0,1
        run_cmd(2'd1, 4'd9, 4'd14, 5'd4, 0, 0, -1, 0, 0, 0);
        // Consumer stall of 10 cycles on the first row
        run_cmd(2'd0, 4'd3, 4'd5, 5'd2, 10, 0, -1, 0, 0, 0);
        // Port B error on col 7 of the first row
        run_cmd(2'd3, 4'd1, 4'd0, 5'd3, 0, 0, 0, 7, 0, 0);
        // Zero rows, then port A error
        run_cmd(2'd2, 4'd5, 4'd8, 5'd0, 0, 0, -1, 0, 0, 0);
        run_cmd(2'd1, 4'd2, 4'd4, 5'd5, 0, 1, -1, 0, 0, 0);
        // Reset during row 2 fetch, with an ignored command while busy
        run_cmd(2'd0, 4'd12, 4'd9, 5'd4, 0, 0, -1, 0, 45, 10);
        @(posedge clk); #1;
        // Full 16-row command and errors at the first/last column of later rows
        run_cmd(2'd3, 4'd15, 4'd6, 5'd16, 0, 0, -1, 0, 0, 0);
        run_cmd(2'd1, 4'd7, 4'd2, 5'd4, 0, 0, 2, 15, 0, 0);
        run_cmd(2'd0, 4'd0, 4'd11, 5'd2, 1, 0, 1, 0, 0, 0);

        for (int t = 0; t < 8; t++) begin
            rc = 5'($urandom_range(1, 16));
            ek = -1;
            ec = 0;
            if ($urandom_range(0, 2) == 0) begin
                ek = $urandom_range(0, int'(rc) - 1);
                ec = $urandom_range(0, 15);
            end
            run_cmd(2'($urandom), 4'($urandom), 4'($urandom), rc,
                    $urandom_range(0, 3), 0, ek, ec, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
